// File: rtl/pio_led_pwm_pkg.sv
// Shared constants for the PIO LED PWM block: register map and timebase widths.
package pio_led_pwm_pkg;

    localparam int ADDR_BITS     = 3;
    localparam int BUS_BITS      = 32;
    localparam int PRESCALE_BITS = 16;

    localparam logic [ADDR_BITS-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_BITS-1:0] ADDR_MODE     = 3'd1;
    localparam logic [ADDR_BITS-1:0] ADDR_DUTY     = 3'd2;
    localparam logic [ADDR_BITS-1:0] ADDR_PRESCALE = 3'd3;
    localparam logic [ADDR_BITS-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_BITS-1:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [ADDR_BITS-1:0] ADDR_STATUS   = 3'd6;

endpackage

// File: rtl/pio_led_pwm_if.sv
// Avalon-MM slave bus bundle for the PIO LED PWM block.
interface pio_led_pwm_if;
    import pio_led_pwm_pkg::*;

    // A write is accepted on any rising clk with chipselect=1 and write_n=0; there
    // are no wait states. readdata always holds the register addressed one cycle earlier.
    logic [ADDR_BITS-1:0] address;
    logic                 chipselect;
    logic                 write_n;
    logic [BUS_BITS-1:0]  writedata;
    logic [BUS_BITS-1:0]  readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/pio_pwm_timebase.sv
// Prescaler, PWM step counter and period-aligned duty shadowing.
module pio_pwm_timebase
    import pio_led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     duty_wr,
    input  logic [PWM_BITS-1:0]      duty_in,
    input  logic                     prescale_wr,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic [PWM_BITS-1:0]      shadow_duty,
    output logic [PWM_BITS-1:0]      pwm_cnt,
    output logic                     pwm_on
);

    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [PWM_BITS-1:0]      active_duty;
    logic                     tick;
    logic                     wrap;

    assign tick   = (pre_cnt == prescale);
    assign wrap   = tick && (pwm_cnt == {PWM_BITS{1'b1}});
    assign pwm_on = (pwm_cnt < active_duty);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            shadow_duty <= '0;
            active_duty <= '0;
        end else begin
            if (duty_wr) begin
                shadow_duty <= duty_in;
            end
            // A prescale rewrite restarts the period and wins over a same-cycle tick.
            if (prescale_wr) begin
                pre_cnt     <= '0;
                pwm_cnt     <= '0;
                active_duty <= shadow_duty;
            end else if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
                if (wrap) begin
                    active_duty <= shadow_duty;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_led_pwm.sv
// Avalon-MM LED port with per-channel PWM dimming and set/clear aliases.
module pio_led_pwm
    import pio_led_pwm_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               PWM_BITS    = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    pio_led_pwm_if.slave     bus,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]         data;
    logic [WIDTH-1:0]         mode;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PWM_BITS-1:0]      shadow_duty;
    logic [PWM_BITS-1:0]      pwm_cnt;
    logic                     pwm_on;
    logic                     wr;
    logic [WIDTH-1:0]         wd;
    logic [BUS_BITS-1:0]      rd_next;
    logic                     unused_wd;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    pio_pwm_timebase #(.PWM_BITS(PWM_BITS)) u_timebase (
        .clk         (clk),
        .reset       (reset),
        .duty_wr     (wr && (bus.address == ADDR_DUTY)),
        .duty_in     (bus.writedata[PWM_BITS-1:0]),
        .prescale_wr (wr && (bus.address == ADDR_PRESCALE)),
        .prescale    (prescale),
        .shadow_duty (shadow_duty),
        .pwm_cnt     (pwm_cnt),
        .pwm_on      (pwm_on)
    );

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:     rd_next[WIDTH-1:0]         = data;
            ADDR_MODE:     rd_next[WIDTH-1:0]         = mode;
            ADDR_DUTY:     rd_next[PWM_BITS-1:0]      = shadow_duty;
            ADDR_PRESCALE: rd_next[PRESCALE_BITS-1:0] = prescale;
            ADDR_STATUS:   rd_next[PWM_BITS-1:0]      = pwm_cnt;
            default:       rd_next                    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data         <= RESET_VALUE;
            mode         <= '0;
            prescale     <= '0;
            bus.readdata <= '0;
            out_port     <= '0;
        end else begin
            bus.readdata <= rd_next;
            // Channels with MODE=0 follow DATA directly; MODE=1 gates them with the PWM.
            out_port     <= data & (~mode | {WIDTH{pwm_on}});
            if (wr) begin
                case (bus.address)
                    ADDR_DATA:     data     <= wd;
                    ADDR_MODE:     mode     <= wd;
                    ADDR_PRESCALE: prescale <= bus.writedata[PRESCALE_BITS-1:0];
                    ADDR_OUTSET:   data     <= data | wd;
                    ADDR_OUTCLEAR: data     <= data & ~wd;
                    default:       data     <= data;
                endcase
            end
        end
    end

endmodule
